// File: rtl/grf_scoreboard_pkg.sv
// Shared definitions for the GRF pending-write scoreboard.
//   REG_AW        : register address width
//   ZERO_REG      : hard-wired zero register index
//   DEF_CNT_W     : default width of a per-register pending counter
//   cnt_max()     : largest count a counter of a given width may hold
//   stall_reason_e: encoding of why decode is held (not exported yet)
package grf_scoreboard_pkg;

    localparam int                REG_AW    = 5;
    localparam logic [REG_AW-1:0] ZERO_REG  = '0;
    localparam int                DEF_CNT_W = 2;
    localparam int                DEF_MAX   = (1 << DEF_CNT_W) - 1;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_RS   = 2'd1,
        STALL_RT   = 2'd2,
        STALL_FULL = 2'd3
    } stall_reason_e;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/grf_sb_cell.sv
// One register's pending-write counter.
// Ports:
//   clk, reset (sync, active-low), flush (sync clear)
//   inc       : a write to this register was issued this cycle
//   rel       : writeback writes this register this cycle
//   busy      : an outstanding write remains after this cycle's release
//   full      : counter saturated and no release this cycle
//   rel_eff   : release that actually decrements (counter non-zero)
//   underflow : release with nothing reserved and no issue to cover it
module grf_sb_cell
    import grf_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic inc,
    input  logic rel,
    output logic busy,
    output logic full,
    output logic rel_eff,
    output logic underflow
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // The last outstanding write landing now is not a hazard: the GRF
        // is written at this edge and the dependent read happens later.
        busy      = (cnt_q != '0) && !((cnt_q == ONE) && rel);
        full      = (cnt_q == MAX) && !rel;
        rel_eff   = rel && (cnt_q != '0);
        underflow = rel && !inc && (cnt_q == '0);

        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && !rel_eff && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end else if (!inc && rel_eff) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// Tracks pending GRF writes: decode reserves a destination, writeback
// releases it, and the two read addresses are checked against pending
// writes to produce the decode stall.
// Ports:
//   clk, reset (sync, active-low), flush (sync clear of reservations)
//   rs_addr/rs_use, rt_addr/rt_use : decode read operands
//   issue_valid/issue_rd/issue_we  : decode issue request
//   wb_valid/wb_rd                 : GRF write port (WE/A3)
//   rs_busy/rt_busy                : operand has an outstanding write
//   stall/issue_fire               : decode hold / issue accepted
//   inflight                       : total outstanding reservations
//   err_underflow                  : sticky release-without-reservation flag
module grf_scoreboard
    import grf_scoreboard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TOT_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_use,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rt_use,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    output logic              issue_fire,
    output logic [TOT_W-1:0]  inflight,
    output logic              err_underflow
);

    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] full_vec;
    logic [NREG-1:0] rel_eff_vec;
    logic [NREG-1:0] uflow_vec;
    logic [NREG-1:1] inc_vec;
    logic [NREG-1:1] rel_vec;

    logic             issue_inc;
    logic             rd_full;
    logic [TOT_W-1:0] inflight_q;
    logic [TOT_W-1:0] inflight_d;
    logic             err_q;
    logic             err_d;

    // Register 0 has no counter: it is never busy, full or released.
    assign busy_vec[0]    = 1'b0;
    assign full_vec[0]    = 1'b0;
    assign rel_eff_vec[0] = 1'b0;
    assign uflow_vec[0]   = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cell
            assign inc_vec[gi] = issue_inc && (issue_rd == REG_AW'(gi));
            assign rel_vec[gi] = wb_valid && (wb_rd == REG_AW'(gi));

            grf_sb_cell #(
                .CNT_W (CNT_W)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .inc       (inc_vec[gi]),
                .rel       (rel_vec[gi]),
                .busy      (busy_vec[gi]),
                .full      (full_vec[gi]),
                .rel_eff   (rel_eff_vec[gi]),
                .underflow (uflow_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        rs_busy    = busy_vec[rs_addr];
        rt_busy    = busy_vec[rt_addr];
        rd_full    = issue_we && full_vec[issue_rd];
        stall      = issue_valid && ((rs_use && rs_busy) || (rt_use && rt_busy) || rd_full);
        issue_fire = issue_valid && !stall;
        issue_inc  = issue_fire && issue_we && (issue_rd != ZERO_REG);

        // At most one issue and one writeback per cycle, so the total moves
        // by at most one in each direction. A saturated register can only
        // take an issue when the same cycle releases it, which cancels out.
        inflight_d = inflight_q + TOT_W'(issue_inc) - TOT_W'(|rel_eff_vec);
        err_d      = err_q || (|uflow_vec);
        if (flush) begin
            inflight_d = '0;
            err_d      = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [4:0] rs_addr;
    logic       rs_use;
    logic [4:0] rt_addr;
    logic       rt_use;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_we;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       rs_busy;
    logic       rt_busy;
    logic       stall;
    logic       issue_fire;
    logic [6:0] inflight;
    logic       err_underflow;

    grf_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .rs_addr       (rs_addr),
        .rs_use        (rs_use),
        .rt_addr       (rt_addr),
        .rt_use        (rt_use),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  stall;
        logic  fire;
        logic  rsb;
        logic  rtb;
        int    inf;
        logic  err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string name, input string fld, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s: got %0d want %0d", name, fld, act, req);
        end
    endtask

    // Monitor: outputs are sampled at the falling edge, half a cycle after
    // the stimulus for that cycle was applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "stall",    int'(stall),         int'(e.stall));
                cmp(e.name, "fire",     int'(issue_fire),    int'(e.fire));
                cmp(e.name, "rs_busy",  int'(rs_busy),       int'(e.rsb));
                cmp(e.name, "rt_busy",  int'(rt_busy),       int'(e.rtb));
                cmp(e.name, "inflight", int'(inflight),      e.inf);
                cmp(e.name, "err",      int'(err_underflow), int'(e.err));
                $display("txn %-10s stall=%0b fire=%0b rsb=%0b rtb=%0b inflight=%0d err=%0b",
                         e.name, stall, issue_fire, rs_busy, rt_busy, inflight, err_underflow);
            end
        end
    end

    // One cycle: drive inputs, queue the expected response, advance.
    task automatic cyc(input string name,
                       input logic iv, input int ird, input logic iwe,
                       input int rsa, input logic rsu, input int rta, input logic rtu,
                       input logic wv, input int wrd, input logic fl,
                       input logic e_stall, input logic e_fire,
                       input logic e_rsb, input logic e_rtb, input int e_inf, input logic e_err);
        exp_t e;
        issue_valid = iv;  issue_rd = 5'(ird); issue_we = iwe;
        rs_addr = 5'(rsa); rs_use = rsu;
        rt_addr = 5'(rta); rt_use = rtu;
        wb_valid = wv;     wb_rd = 5'(wrd);    flush = fl;
        e.name = name; e.stall = e_stall; e.fire = e_fire;
        e.rsb = e_rsb; e.rtb = e_rtb; e.inf = e_inf; e.err = e_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0;
        rs_addr = '0; rs_use = 1'b0; rt_addr = '0; rt_use = 1'b0;
        wb_valid = 1'b0; wb_rd = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Reset then idle: nothing busy on any address, no-write issues fire.
        cyc("rst_idle", 0,0,0, 0,0,0,0, 0,0,0,  0,0,0,0,0,0);
        for (int a = 0; a < 32; a++)
            cyc("rst_sweep", 1,0,0, a,1,31-a,1, 0,0,0,  0,1,0,0,0,0);

        // RAW hazard on r8, resolved by same-cycle writeback bypass.
        cyc("raw_iss",  1,8,1, 0,0,0,0, 0,0,0,  0,1,0,0,0,0);
        cyc("raw_stl",  1,0,0, 8,1,8,0, 0,0,0,  1,0,1,1,1,0);
        cyc("raw_byp",  1,0,0, 8,1,8,0, 1,8,0,  0,1,0,0,1,0);
        cyc("raw_done", 0,0,0, 8,1,8,1, 0,0,0,  0,0,0,0,0,0);

        // Saturation on r5: three reservations then full.
        cyc("sat_1",    1,5,1, 5,0,0,0, 0,0,0,  0,1,0,0,0,0);
        cyc("sat_2",    1,5,1, 5,0,0,0, 0,0,0,  0,1,1,0,1,0);
        cyc("sat_3",    1,5,1, 5,0,0,0, 0,0,0,  0,1,1,0,2,0);
        cyc("sat_full", 1,5,1, 5,0,0,0, 0,0,0,  1,0,1,0,3,0);
        cyc("sat_wb",   1,5,1, 5,0,0,0, 1,5,0,  0,1,1,0,3,0);
        cyc("sat_hold", 0,0,0, 0,0,5,0, 0,0,0,  0,0,0,1,3,0);
        cyc("sat_dr3",  0,0,0, 5,0,0,0, 1,5,0,  0,0,1,0,3,0);
        cyc("sat_dr2",  0,0,0, 5,0,0,0, 1,5,0,  0,0,1,0,2,0);
        cyc("sat_dr1",  0,0,0, 5,0,0,0, 1,5,0,  0,0,0,0,1,0);
        cyc("sat_end",  0,0,0, 5,1,5,1, 0,0,0,  0,0,0,0,0,0);

        // Register 0 is never reserved, busy or flagged.
        for (int i = 0; i < 10; i++)
            cyc("zero_iss", 1,0,1, 0,0,0,0, 0,0,0,  0,1,0,0,0,0);
        cyc("zero_rd",  1,0,0, 0,1,0,1, 0,0,0,  0,1,0,0,0,0);
        cyc("zero_wb",  0,0,0, 0,0,0,0, 1,0,0,  0,0,0,0,0,0);
        cyc("zero_chk", 0,0,0, 0,0,0,0, 0,0,0,  0,0,0,0,0,0);

        // Underflow on r12: sticky through flush, counter does not wrap.
        cyc("uf_wb",    0,0,0, 12,0,0,0, 1,12,0, 0,0,0,0,0,0);
        cyc("uf_flag",  0,0,0, 12,1,12,1, 0,0,0, 0,0,0,0,0,1);
        cyc("uf_flush", 0,0,0, 12,0,0,0, 0,0,1,  0,0,0,0,0,1);
        cyc("uf_kept",  1,12,1, 12,0,0,0, 0,0,0, 0,1,0,0,0,1);
        cyc("uf_res",   0,0,0, 12,0,12,0, 0,0,0, 0,0,1,1,1,1);
        cyc("uf_rel",   1,0,0, 12,1,0,0, 1,12,0, 0,1,0,0,1,1);
        cyc("uf_zero",  0,0,0, 12,0,0,0, 0,0,0,  0,0,0,0,0,1);

        // Flush mid-operation drops reservations and same-cycle traffic.
        cyc("fl_r3",    1,3,1, 0,0,0,0, 0,0,0,  0,1,0,0,0,1);
        cyc("fl_r4a",   1,4,1, 3,0,0,0, 0,0,0,  0,1,1,0,1,1);
        cyc("fl_r4b",   1,4,1, 3,0,4,0, 0,0,0,  0,1,1,1,2,1);
        cyc("fl_go",    1,7,1, 3,0,4,0, 1,4,1,  0,1,1,1,3,1);
        cyc("fl_chk34", 1,0,0, 3,1,4,1, 0,0,0,  0,1,0,0,0,1);
        cyc("fl_chk7",  1,0,0, 7,1,4,1, 0,0,0,  0,1,0,0,0,1);

        // Reset clears the sticky flag and overrides a same-cycle issue.
        reset = 1'b0;
        cyc("rst2_iss", 1,9,1, 0,0,0,0, 0,0,0,  0,1,0,0,0,1);
        reset = 1'b1;
        cyc("rst2_chk", 0,0,0, 9,1,9,1, 0,0,0,  0,0,0,0,0,0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
